// File: rtl/bridge_arbiter_2m.sv
// bridge_arbiter_2m: round-robin arbiter for two sides sharing one bus bridge; ports clk, rst, req_a/req_b in, done in, grant_a/grant_b/busy/owner/abort/timeout out; optional watchdog via ARB_TIMEOUT_EN
module bridge_arbiter_2m #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic done,
  output logic grant_a,
  output logic grant_b,
  output logic busy,
  output logic owner,
  output logic abort,
  output logic timeout
);
  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, RELEASE} state_t;
  state_t state, nxt;
  logic prio, held, req_own, expired, pick_b;
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT out of range");
  end
  assign held = state == GRANT_A || state == GRANT_B;
  assign req_own = state == GRANT_B ? req_b : req_a;
  assign pick_b = req_b && (!req_a || prio);
  assign grant_a = state == GRANT_A;
  assign grant_b = state == GRANT_B;
  assign busy = grant_a || grant_b;
`ifdef ARB_TIMEOUT_EN
  logic [15:0] cnt;
  logic timeout_q;
  assign expired = cnt == 16'(TIMEOUT - 1);
  assign timeout = timeout_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt <= held ? cnt + 16'd1 : 16'd0;
      timeout_q <= held && !done && req_own && expired;
    end
  end
`else
  assign expired = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb begin
    nxt = state;
    if (held) nxt = (done || !req_own || expired) ? RELEASE : state;
    else nxt = pick_b ? GRANT_B : req_a ? GRANT_A : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio <= 1'b0;
      owner <= 1'b0;
      abort <= 1'b0;
    end else begin
      state <= nxt;
      abort <= held && !done && !req_own;
      if (held && nxt == RELEASE) prio <= state == GRANT_A;
      if (nxt == GRANT_A) owner <= 1'b0;
      else if (nxt == GRANT_B) owner <= 1'b1;
    end
  end
endmodule
